// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write port shared by the
// program loader (slave) and its byte source / memory harness (master).
interface program_loader_if #(
    parameter int unsigned ADDRESS_WIDTH     = 11,
    parameter int unsigned INSTRUCTION_WIDTH = 16
) ();
    logic [7:0]                   byte_in;
    logic                         byte_valid_in;
    logic                         byte_ready_out;
    logic [ADDRESS_WIDTH-1:0]     imem_addr_out;
    logic [INSTRUCTION_WIDTH-1:0] imem_data_out;
    logic                         imem_wr_out;

    modport slave (
        input  byte_in, byte_valid_in,
        output byte_ready_out, imem_addr_out, imem_data_out, imem_wr_out
    );

    modport master (
        output byte_in, byte_valid_in,
        input  byte_ready_out, imem_addr_out, imem_data_out, imem_wr_out
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed byte stream (A5, LEN_H, LEN_L, N big-endian words, CHK) into
// instruction memory, then releases the CPU. Optional macro: LOADER_TIMEOUT_EN.
module program_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH     = 11,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    program_loader_if.slave        bus,
    output logic                   cpu_reset_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic [ADDRESS_WIDTH:0] words_loaded_out
);

    localparam int unsigned CNT_W     = ADDRESS_WIDTH + 1;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDRESS_WIDTH);

    typedef enum logic [2:0] {
        ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;

    state_t     state;
    logic [7:0] len_hi_q;
    logic [15:0] len_q;
    logic [7:0] data_hi_q;
    logic [7:0] sum_q;

    logic             accept_c;
    logic             in_frame_c;
    logic [15:0]      len_c;
    logic [7:0]       sum_next_c;
    logic [CNT_W-1:0] words_next_c;
    logic             last_word_c;
    logic             timeout_c;

    assign accept_c     = bus.byte_valid_in && bus.byte_ready_out;
    assign in_frame_c   = (state == ST_LEN_H) || (state == ST_LEN_L) || (state == ST_DATA_H) ||
                          (state == ST_DATA_L) || (state == ST_CHECK);
    assign len_c        = {len_hi_q, bus.byte_in};
    assign sum_next_c   = sum_q + bus.byte_in;
    assign words_next_c = words_loaded_out + CNT_W'(1);
    assign last_word_c  = (17'(words_next_c) == 17'(len_q));

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] idle_q;

    // Counts consecutive cycles without an accepted byte while a frame is open
    assign timeout_c = in_frame_c && !accept_c && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            idle_q <= '0;
        end else if (!in_frame_c || accept_c || timeout_c) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TO_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign timeout_c          = 1'b0;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Frame parser; every output is a register updated on the transition edge
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state              <= ST_SYNC;
            len_hi_q           <= '0;
            len_q              <= '0;
            data_hi_q          <= '0;
            sum_q              <= '0;
            bus.byte_ready_out <= 1'b1;
            bus.imem_addr_out  <= '0;
            bus.imem_data_out  <= '0;
            bus.imem_wr_out    <= 1'b0;
            cpu_reset_out      <= 1'b0;
            busy_out           <= 1'b1;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
            words_loaded_out   <= '0;
        end else begin
            bus.imem_wr_out <= 1'b0;
            if (timeout_c) begin
                state              <= ST_ERROR;
                bus.byte_ready_out <= 1'b0;
                busy_out           <= 1'b0;
                error_out          <= 1'b1;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (accept_c && (bus.byte_in == SYNC_BYTE)) begin
                            state            <= ST_LEN_H;
                            sum_q            <= '0;
                            words_loaded_out <= '0;
                        end
                    end
                    ST_LEN_H: begin
                        if (accept_c) begin
                            len_hi_q <= bus.byte_in;
                            state    <= ST_LEN_L;
                        end
                    end
                    ST_LEN_L: begin
                        if (accept_c) begin
                            len_q <= len_c;
                            if ((len_c == 16'd0) || (17'(len_c) > MAX_WORDS)) begin
                                state              <= ST_ERROR;
                                bus.byte_ready_out <= 1'b0;
                                busy_out           <= 1'b0;
                                error_out          <= 1'b1;
                            end else begin
                                state <= ST_DATA_H;
                            end
                        end
                    end
                    ST_DATA_H: begin
                        if (accept_c) begin
                            data_hi_q <= bus.byte_in;
                            sum_q     <= sum_next_c;
                            state     <= ST_DATA_L;
                        end
                    end
                    ST_DATA_L: begin
                        if (accept_c) begin
                            bus.imem_data_out <= INSTRUCTION_WIDTH'({data_hi_q, bus.byte_in});
                            bus.imem_addr_out <= words_loaded_out[ADDRESS_WIDTH-1:0];
                            bus.imem_wr_out   <= 1'b1;
                            words_loaded_out  <= words_next_c;
                            sum_q             <= sum_next_c;
                            state             <= last_word_c ? ST_CHECK : ST_DATA_H;
                        end
                    end
                    ST_CHECK: begin
                        if (accept_c) begin
                            bus.byte_ready_out <= 1'b0;
                            busy_out           <= 1'b0;
                            if (sum_next_c == 8'd0) begin
                                state         <= ST_DONE;
                                done_out      <= 1'b1;
                                cpu_reset_out <= 1'b1;
                            end else begin
                                state     <= ST_ERROR;
                                error_out <= 1'b1;
                            end
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        if (start_in) begin
                            state              <= ST_SYNC;
                            bus.byte_ready_out <= 1'b1;
                            busy_out           <= 1'b1;
                            done_out           <= 1'b0;
                            error_out          <= 1'b0;
                            cpu_reset_out      <= 1'b0;
                            words_loaded_out   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level reference model.
module tb_program_loader;

    localparam int unsigned AW = 11;
    localparam int unsigned IW = 16;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b0;
    logic          start_in = 1'b0;
    logic          cpu_reset_out;
    logic          busy_out;
    logic          done_out;
    logic          error_out;
    logic [AW:0]   words_loaded_out;

    int total = 0;
    int bad   = 0;

    program_loader_if #(.ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bus ();

    program_loader #(
        .INSTRUCTION_WIDTH (IW),
        .ADDRESS_WIDTH     (AW),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clock_in         (clock_in),
        .reset_in         (reset_in),
        .start_in         (start_in),
        .bus              (bus.slave),
        .cpu_reset_out    (cpu_reset_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .error_out        (error_out),
        .words_loaded_out (words_loaded_out)
    );

    always #5 clock_in = ~clock_in;

    // Write monitor
    logic [AW-1:0] cap_addr[$];
    logic [IW-1:0] cap_data[$];

    always @(negedge clock_in) begin
        if (bus.imem_wr_out === 1'b1) begin
            cap_addr.push_back(bus.imem_addr_out);
            cap_data.push_back(bus.imem_data_out);
        end
    end

    // Reference model results
    logic [15:0] exp_words[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_n;

    // Frame-level model: skip to sync, read length, words, checksum
    task automatic model(input logic [7:0] s[$]);
        int p = 0;
        int n;
        int sum = 0;
        exp_words = {};
        while (p < s.size() && s[p] != 8'hA5) p++;
        p++;
        n = int'({s[p], s[p+1]});
        p += 2;
        if (n == 0 || n > (1 << AW)) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_n    = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_words.push_back({s[p+2*i], s[p+2*i+1]});
                sum += int'(s[p+2*i]) + int'(s[p+2*i+1]);
            end
            sum += int'(s[p+2*n]);
            exp_done = ((sum % 256) == 0);
            exp_err  = !exp_done;
            exp_n    = n;
        end
    endtask

    function automatic int write_errors();
        int e = 0;
        if (cap_addr.size() != exp_words.size()) return 1 + exp_words.size();
        foreach (exp_words[i]) begin
            if (cap_addr[i] !== AW'(i) || cap_data[i] !== exp_words[i]) e++;
        end
        return e;
    endfunction

    // Drives bytes one per accepted cycle, with 'gap' idle cycles between bytes
    task automatic send_stream(input logic [7:0] s[$], input int gap);
        foreach (s[i]) begin
            int tries = 0;
            bus.byte_in       = s[i];
            bus.byte_valid_in = 1'b1;
            while (bus.byte_ready_out !== 1'b1 && tries < 20) begin
                @(negedge clock_in);
                tries++;
            end
            if (bus.byte_ready_out !== 1'b1) begin
                total++; bad++;
                $display("FAIL send_timeout byte %0d: ready=%b want 1", i, bus.byte_ready_out);
                bus.byte_valid_in = 1'b0;
                return;
            end
            @(negedge clock_in);
            if (gap > 0) begin
                bus.byte_valid_in = 1'b0;
                repeat (gap) @(negedge clock_in);
            end
        end
        bus.byte_valid_in = 1'b0;
        repeat (3) @(negedge clock_in);
    endtask

    task automatic run_frame(input logic [7:0] s[$], input int gap);
        cap_addr = {};
        cap_data = {};
        model(s);
        send_stream(s, gap);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        @(negedge clock_in);
    endtask

    task automatic test_reset();
        total++;
        if ({bus.byte_ready_out, busy_out, cpu_reset_out, bus.imem_wr_out, done_out, error_out} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags got %b want 110000",
                     {bus.byte_ready_out, busy_out, cpu_reset_out, bus.imem_wr_out, done_out, error_out});
        end
        total++;
        if (bus.imem_addr_out !== '0 || bus.imem_data_out !== '0 || words_loaded_out !== '0) begin
            bad++;
            $display("FAIL reset_buses addr=%h data=%h wl=%0d want 0", bus.imem_addr_out,
                     bus.imem_data_out, words_loaded_out);
        end
    endtask

    task automatic test_basic_load(input int gap, input string tag);
        logic [7:0] s[$] = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h05, 8'h20, 8'h03, 8'hC8};
        int e;
        run_frame(s, gap);
        e = write_errors();
        total++;
        if (e !== 0 || cap_data.size() != 2 || cap_data[0] !== 16'h1005 || cap_data[1] !== 16'h2003) begin
            bad++;
            $display("FAIL %s_writes got %0d writes (%0d bad) want 2 (1005,2003)", tag, cap_data.size(), e);
        end
        total++;
        if ({done_out, error_out, cpu_reset_out, bus.byte_ready_out, busy_out} !== 5'b10100 ||
            words_loaded_out !== (AW+1)'(2)) begin
            bad++;
            $display("FAIL %s_status got d=%b e=%b c=%b r=%b b=%b wl=%0d want 1 0 1 0 0 wl=2", tag,
                     done_out, error_out, cpu_reset_out, bus.byte_ready_out, busy_out, words_loaded_out);
        end
    endtask

    task automatic test_not_consumed();
        cap_addr = {};
        bus.byte_in       = 8'hA5;
        bus.byte_valid_in = 1'b1;
        repeat (5) @(negedge clock_in);
        bus.byte_valid_in = 1'b0;
        @(negedge clock_in);
        total++;
        if (done_out !== 1'b1 || bus.byte_ready_out !== 1'b0 || cap_addr.size() != 0 ||
            words_loaded_out !== (AW+1)'(2)) begin
            bad++;
            $display("FAIL idle_valid got done=%b ready=%b writes=%0d wl=%0d want 1 0 0 2",
                     done_out, bus.byte_ready_out, cap_addr.size(), words_loaded_out);
        end
        pulse_start();
        total++;
        if ({done_out, error_out, cpu_reset_out, bus.byte_ready_out, busy_out} !== 5'b00011 ||
            words_loaded_out !== '0) begin
            bad++;
            $display("FAIL start_from_done got d=%b e=%b c=%b r=%b b=%b wl=%0d want 0 0 0 1 1 wl=0",
                     done_out, error_out, cpu_reset_out, bus.byte_ready_out, busy_out, words_loaded_out);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$] = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h05, 8'h20, 8'h03, 8'hC9};
        int e;
        run_frame(s, 0);
        e = write_errors();
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL badchk_writes got %0d writes (%0d bad) want 2", cap_data.size(), e);
        end
        total++;
        if (error_out !== 1'b1 || done_out !== 1'b0 || cpu_reset_out !== 1'b0 || words_loaded_out !== (AW+1)'(2)) begin
            bad++;
            $display("FAIL badchk_status got e=%b d=%b c=%b wl=%0d want 1 0 0 2",
                     error_out, done_out, cpu_reset_out, words_loaded_out);
        end
        pulse_start();
        total++;
        if (error_out !== 1'b0 || bus.byte_ready_out !== 1'b1 || busy_out !== 1'b1) begin
            bad++;
            $display("FAIL start_from_error got e=%b r=%b b=%b want 0 1 1", error_out, bus.byte_ready_out, busy_out);
        end
    endtask

    task automatic test_bad_length(input logic [7:0] s[$], input string tag);
        run_frame(s, 0);
        total++;
        if (error_out !== 1'b1 || done_out !== 1'b0 || cap_addr.size() != 0 || words_loaded_out !== '0 ||
            exp_err !== 1'b1) begin
            bad++;
            $display("FAIL %s got e=%b d=%b writes=%0d wl=%0d want 1 0 0 0", tag,
                     error_out, done_out, cap_addr.size(), words_loaded_out);
        end
        pulse_start();
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[$] = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h05, 8'h20};
        cap_addr = {};
        cap_data = {};
        send_stream(s, 0);
        reset_in = 1'b0;
        repeat (3) @(negedge clock_in);
        total++;
        if (cap_addr.size() != 1 || cap_addr[0] !== '0 || cap_data[0] !== 16'h1005) begin
            bad++;
            $display("FAIL midreset_writes got %0d writes want 1 (0:1005)", cap_addr.size());
        end
        test_reset();
        reset_in = 1'b1;
        @(negedge clock_in);
        test_basic_load(0, "after_reset");
        pulse_start();
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] s[$];
            int n = $urandom_range(1, 6);
            int sum = 0;
            int gap = $urandom_range(0, 2);
            int e;
            logic [7:0] b;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                s.push_back(b == 8'hA5 ? 8'h5A : b);
            end
            s.push_back(8'hA5);
            s.push_back(8'h00);
            s.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) begin
                b = 8'($urandom_range(0, 255));
                s.push_back(b);
                sum += int'(b);
            end
            b = 8'(256 - (sum % 256));
            if ($urandom_range(0, 3) == 0) b = b + 8'd1;
            s.push_back(b);
            run_frame(s, gap);
            e = write_errors();
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL rand%0d_writes got %0d writes (%0d bad) want %0d", it, cap_addr.size(), e, exp_n);
            end
            total++;
            if (done_out !== exp_done || error_out !== exp_err || cpu_reset_out !== exp_done ||
                words_loaded_out !== (AW+1)'(exp_n)) begin
                bad++;
                $display("FAIL rand%0d_status got d=%b e=%b c=%b wl=%0d want d=%b e=%b wl=%0d", it,
                         done_out, error_out, cpu_reset_out, words_loaded_out, exp_done, exp_err, exp_n);
            end
            pulse_start();
        end
    endtask

    task automatic test_max_len();
        logic [7:0] s[$] = {8'hA5, 8'h08, 8'h00};
        int sum = 0;
        int e;
        logic [7:0] b;
        for (int i = 0; i < 2 * (1 << AW); i++) begin
            b = 8'($urandom_range(0, 255));
            s.push_back(b);
            sum += int'(b);
        end
        s.push_back(8'(256 - (sum % 256)));
        run_frame(s, 0);
        e = write_errors();
        total++;
        if (e !== 0 || done_out !== 1'b1 || words_loaded_out !== (AW+1)'(1 << AW)) begin
            bad++;
            $display("FAIL max_len got writes=%0d bad=%0d done=%b wl=%0d want %0d 0 1 %0d",
                     cap_addr.size(), e, done_out, words_loaded_out, 1 << AW, 1 << AW);
        end
        pulse_start();
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] s[$] = {8'hA5, 8'h00};
        send_stream(s, 0);
        repeat (11) @(negedge clock_in);
        total++;
        if (error_out !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got error=%b want 0", error_out);
        end
        repeat (4) @(negedge clock_in);
        total++;
        if (error_out !== 1'b1 || bus.byte_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL timeout got error=%b ready=%b want 1 0", error_out, bus.byte_ready_out);
        end
        pulse_start();
    endtask
`endif

    initial begin
        bus.byte_in       = '0;
        bus.byte_valid_in = 1'b0;
        repeat (3) @(negedge clock_in);
        test_reset();
        reset_in = 1'b1;
        @(negedge clock_in);
        test_basic_load(0, "basic");
        test_not_consumed();
        test_bad_checksum();
        test_bad_length({8'h11, 8'h22, 8'hA5, 8'h00, 8'h00}, "zero_len");
        test_bad_length({8'hA5, 8'h08, 8'h01}, "over_len");
        test_basic_load(2, "throttled");
        pulse_start();
        test_reset_midload();
        test_random_frames();
        test_max_len();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Fills instruction memory with a program received as a byte stream, then releases the accumulator CPU from reset.
- Builds the INSTRUCTION_WIDTH words that the control unit later fetches and decodes.
- Sits between a byte source (UART receiver or test harness) and the instruction-memory write port.
- Holds the CPU in reset while it loads.

Parameters:
- INSTRUCTION_WIDTH, 16: width of one instruction word. Fixed at two bytes.
- ADDRESS_WIDTH, 11: instruction-memory address width. Maximum program size is 2^ADDRESS_WIDTH words.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout. Used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clock_in  input  1  system clock, rising edge
- reset_in  input  1  asynchronous reset, active-low
- start_in  input  1  single-cycle pulse; starts a new load from DONE or ERROR
- byte_in  input  8  incoming byte
- byte_valid_in  input  1  byte_in is valid
- byte_ready_out  output  1  loader can accept a byte; transfer occurs when valid && ready
- imem_addr_out  output  ADDRESS_WIDTH  instruction-memory write address
- imem_data_out  output  INSTRUCTION_WIDTH  instruction-memory write data
- imem_wr_out  output  1  instruction-memory write strobe, one cycle per word
- cpu_reset_out  output  1  active-low reset to the CPU; 0 = CPU held in reset
- busy_out  output  1  load in progress
- done_out  output  1  last load succeeded; level output
- error_out  output  1  last load failed; level output
- words_loaded_out  output  ADDRESS_WIDTH+1  words written in the current or last load

Behaviour:
- Reset (reset_in=0, asynchronous):
  - state=SYNC
  - cpu_reset_out=0, imem_wr_out=0, done_out=0, error_out=0
  - busy_out=1, byte_ready_out=1
  - imem_addr_out=0, imem_data_out=0, words_loaded_out=0
  - A load therefore begins automatically after reset.
- Frame format:
  - sync byte 0xA5
  - LEN_H, LEN_L: word count N, big-endian 16-bit
  - N words, high byte first
  - CHK: sum of all word bytes plus CHK must equal 0 mod 256
- States: SYNC, LEN_H, LEN_L, DATA_H, DATA_L, CHECK, DONE, ERROR. All outputs are registered.
- SYNC:
  - Accepted bytes other than 0xA5 are discarded; state stays SYNC.
  - 0xA5 moves to LEN_H and clears the checksum accumulator and the word counter.
- LEN_H, LEN_L:
  - Latch N.
  - After LEN_L: if N==0 or N>2^ADDRESS_WIDTH, go to ERROR on the next edge. Otherwise go to DATA_H.
- DATA_H: latch the high byte and add it to the checksum; go to DATA_L.
- DATA_L: on acceptance, on the next edge:
  - imem_data_out = {high, low}, imem_addr_out = word index
  - imem_wr_out=1 for exactly one cycle
  - words_loaded_out increments
  - Word index wraps never; the length check guarantees index < 2^ADDRESS_WIDTH.
- After word N, go to CHECK; otherwise go to DATA_H. A byte may be accepted in the same cycle that imem_wr_out is high. Throughput is one byte per cycle.
- CHECK: on acceptance, if (accumulator + byte) mod 256 == 0 go to DONE, else ERROR.
- DONE: byte_ready_out=0, busy_out=0, done_out=1, cpu_reset_out=1.
- ERROR: byte_ready_out=0, busy_out=0, error_out=1, cpu_reset_out=0.
  - Words already written remain in memory; no rollback.
- byte_ready_out=1 in SYNC through CHECK. busy_out=1 in those same states.
- start_in in DONE or ERROR:
  - next edge: state=SYNC, cpu_reset_out=0, done_out=0, error_out=0, words_loaded_out=0
  - start_in in any other state is ignored.
- byte_valid_in while ready=0: no effect; the byte is not consumed.
- reset_in asserted mid-load: immediate return to the reset values above. Any partially assembled word is dropped and no write is issued.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A counter clears on every accepted byte.
  - In LEN_H through CHECK, TIMEOUT_CYCLES consecutive cycles without an accepted byte force ERROR.
  - The counter is idle in SYNC, DONE and ERROR.
- Not defined: no counter exists and the loader waits indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- After reset, stream A5 00 02 10 05 20 03 C8, one byte per cycle:
  - writes addr0=0x1005, then addr1=0x2003, each a one-cycle strobe
  - then done_out=1, cpu_reset_out=1, words_loaded_out=2, byte_ready_out=0
- Same stream with checksum C9:
  - both writes occur
  - error_out=1, cpu_reset_out stays 0, words_loaded_out=2
  - start_in then clears error_out and returns to SYNC
- Stream 11 22 A5 00 00:
  - 0x11 and 0x22 are discarded
  - the zero length forces ERROR; no imem_wr_out pulse occurs
- Stream A5 08 01 (N=2049 at ADDRESS_WIDTH=11) -> ERROR, no writes.
- Throttle byte_valid_in to every third cycle on the first stream -> identical writes and result.
- Drop reset_in after A5 00 02 10 05 20:
  - no second write; all outputs at reset values
  - a full valid frame afterwards loads correctly
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, send A5 00 then stall 16 cycles -> error_out=1.
